ps2_key_decoder: RTL and testbench

Upstream input stage for the Tetris game controller. Receives PS/2 keyboard frames (scan code set 2) and tracks E0 (extended) and F0 (break) prefixes. Translates arrow-key make codes into the 3-bit move command consumed by the game control block: 000 idle, 100 down, 101 left, 110 right, 111 rotate. Each command is a single-clock pulse, because the game control block acts on every clock the command is non-idle.

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/ps2_rx.sv | 130 +++++++++++++
 rtl/ps2_key_decoder.sv | 90 +++++++++
 tb/tb_ps2_key_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Constants shared by the PS/2 input stage and the game control block:
// move commands, scan-code set 2 values and the frame parity helper.
package tetris_pkg;

  localparam logic [2:0] CMD_IDLE   = 3'b000;
  localparam logic [2:0] CMD_DOWN   = 3'b100;
  localparam logic [2:0] CMD_LEFT   = 3'b101;
  localparam logic [2:0] CMD_RIGHT  = 3'b110;
  localparam logic [2:0] CMD_ROTATE = 3'b111;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // PS/2 frames carry odd parity across the eight data bits and the parity bit.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, falling-edge
// strobe, start/data/parity/stop FSM and partial-frame timeout.
module ps2_rx
  import tetris_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr,
  output logic       rxTimeout
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]      clkSync_r;
  logic [1:0]      dataSync_r;
  logic [FC_W-1:0] filtCnt_r;
  logic            filtClk_r;
  logic            filtClkDly_r;
  logic            fallEdge_s;
  logic            dataBit_s;
  logic [1:0]      state_r;
  logic [2:0]      bitCnt_r;
  logic [7:0]      shift_r;
  logic            parity_r;
  logic [TO_W-1:0] toCnt_r;

  assign fallEdge_s = filtClkDly_r & ~filtClk_r;
  assign dataBit_s  = dataSync_r[1];

  // Synchronize both lines and hold the filtered clock until FILTER_LEN agreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkSync_r    <= 2'b11;
      dataSync_r   <= 2'b11;
      filtCnt_r    <= '0;
      filtClk_r    <= 1'b1;
      filtClkDly_r <= 1'b1;
    end else begin
      clkSync_r    <= {clkSync_r[0], ps2Clk};
      dataSync_r   <= {dataSync_r[0], ps2Data};
      filtClkDly_r <= filtClk_r;
      if (clkSync_r[1] == filtClk_r) begin
        filtCnt_r <= '0;
      end else if (filtCnt_r == FC_W'(FILTER_LEN - 1)) begin
        filtClk_r <= clkSync_r[1];
        filtCnt_r <= '0;
      end else begin
        filtCnt_r <= filtCnt_r + FC_W'(1);
      end
    end
  end

  // Frame FSM; timeout and bit handling never overlap since one needs an edge and the other its absence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      bitCnt_r  <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      toCnt_r   <= '0;
      rxByte    <= 8'h00;
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      rxTimeout <= 1'b0;
    end else begin
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      rxTimeout <= 1'b0;
      if ((state_r != ST_IDLE) && !fallEdge_s) begin
        if (toCnt_r == TO_W'(TIMEOUT_CYCLES)) begin
          state_r   <= ST_IDLE;
          frameErr  <= 1'b1;
          rxTimeout <= 1'b1;
          toCnt_r   <= '0;
        end else begin
          toCnt_r <= toCnt_r + TO_W'(1);
        end
      end else begin
        toCnt_r <= '0;
      end
      if (fallEdge_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!dataBit_s) begin
              state_r  <= ST_DATA;
              bitCnt_r <= 3'd0;
            end else begin
              frameErr <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_r  <= {dataBit_s, shift_r[7:1]};
            bitCnt_r <= bitCnt_r + 3'd1;
            if (bitCnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_r <= dataBit_s;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            if (dataBit_s && oddParityOk(shift_r, parity_r)) begin
              rxByte  <= shift_r;
              rxValid <= 1'b1;
            end else begin
              frameErr <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the Tetris controller: tracks E0/F0 prefixes and
// turns arrow make codes into one-cycle move commands. Define PS2_WASD_EN to map W/A/S/D too.
module ps2_key_decoder
  import tetris_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keyboard_signal,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic       rxTimeout_s;
  logic       extFlag_r;
  logic       brkFlag_r;
  logic [2:0] extCmd_s;
  logic [2:0] plainCmd_s;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2Clk    (ps2_clk),
    .ps2Data   (ps2_data),
    .rxByte    (rx_byte),
    .rxValid   (rx_valid),
    .frameErr  (frame_err),
    .rxTimeout (rxTimeout_s)
  );

  // Command lookup for the current byte, extended and plain code pages.
  always_comb begin
    extCmd_s   = CMD_IDLE;
    plainCmd_s = CMD_IDLE;
    case (rx_byte)
      SC_DOWN:  extCmd_s = CMD_DOWN;
      SC_LEFT:  extCmd_s = CMD_LEFT;
      SC_RIGHT: extCmd_s = CMD_RIGHT;
      SC_UP:    extCmd_s = CMD_ROTATE;
      default:  extCmd_s = CMD_IDLE;
    endcase
`ifdef PS2_WASD_EN
    case (rx_byte)
      SC_S:    plainCmd_s = CMD_DOWN;
      SC_A:    plainCmd_s = CMD_LEFT;
      SC_D:    plainCmd_s = CMD_RIGHT;
      SC_W:    plainCmd_s = CMD_ROTATE;
      default: plainCmd_s = CMD_IDLE;
    endcase
`else
    plainCmd_s = CMD_IDLE;
`endif
  end

  // Prefix tracking and single-cycle command pulse one clock after rx_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      extFlag_r       <= 1'b0;
      brkFlag_r       <= 1'b0;
      keyboard_signal <= CMD_IDLE;
    end else begin
      keyboard_signal <= CMD_IDLE;
      if (rxTimeout_s) begin
        extFlag_r <= 1'b0;
        brkFlag_r <= 1'b0;
      end else if (rx_valid) begin
        case (rx_byte)
          SC_EXT:   extFlag_r <= 1'b1;
          SC_BREAK: brkFlag_r <= 1'b1;
          default: begin
            extFlag_r <= 1'b0;
            brkFlag_r <= 1'b0;
            if (!brkFlag_r) begin
              keyboard_signal <= extFlag_r ? extCmd_s : plainCmd_s;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, a negedge monitor
// recording pulses, and immediate-assertion checks against hand-computed values.
module tb_ps2_key_decoder;

  localparam int H       = 20;
  localparam int TIMEOUT = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] keyboard_signal;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         rxCount = 0;
  int         errCount = 0;
  int         lastRxCyc = 0;
  logic [7:0] lastRx = 8'h00;
  int         cmdN = 0;
  logic [2:0] cmdVal [0:63];
  int         cmdCyc [0:63];

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .keyboard_signal (keyboard_signal),
    .rx_byte         (rx_byte),
    .rx_valid        (rx_valid),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      rxCount   <= rxCount + 1;
      lastRxCyc <= cyc;
      lastRx    <= rx_byte;
    end
    if (frame_err) errCount <= errCount + 1;
    if (keyboard_signal != 3'b000 && cmdN < 64) begin
      cmdVal[cmdN] <= keyboard_signal;
      cmdCyc[cmdN] <= cyc;
      cmdN         <= cmdN + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    ps2_data = b;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(bits[i]);
    repeat (H) @(posedge clk);
    ps2_data = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  initial begin
    int n0;
    int e0;
    int r0;

    // reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_kbd", 32'(keyboard_signal), 32'h0);
    check("reset_rxbyte", 32'(rx_byte), 32'h0);
    check("reset_rxvalid", 32'(rx_valid), 32'h0);
    check("reset_frameerr", 32'(frame_err), 32'h0);
    rst = 1'b1;
    repeat (50) @(posedge clk);

    // E0 72 -> DOWN one clock after rx_valid of the 72
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'h72, 1'b0);
    @(negedge clk);
    check("t1_rxcount", 32'(rxCount), 32'd2);
    check("t1_lastrx", 32'(lastRx), 32'h72);
    check("t1_cmdn", 32'(cmdN), 32'd1);
    check("t1_cmdval", 32'(cmdVal[0]), 32'h4);
    check("t1_latency", 32'(cmdCyc[0]), 32'(lastRxCyc + 1));
    check("t1_noerr", 32'(errCount), 32'd0);

    // E0 6B, E0 74, E0 75 -> LEFT, RIGHT, ROTATE
    sendFrame(8'hE0, 1'b0); sendFrame(8'h6B, 1'b0);
    sendFrame(8'hE0, 1'b0); sendFrame(8'h74, 1'b0);
    sendFrame(8'hE0, 1'b0); sendFrame(8'h75, 1'b0);
    @(negedge clk);
    check("t2_cmdn", 32'(cmdN), 32'd4);
    check("t2_left", 32'(cmdVal[1]), 32'h5);
    check("t2_right", 32'(cmdVal[2]), 32'h6);
    check("t2_rotate", 32'(cmdVal[3]), 32'h7);

    // break sequence gives nothing; plain 1B only with WASD
    sendFrame(8'hE0, 1'b0); sendFrame(8'hF0, 1'b0); sendFrame(8'h72, 1'b0);
    @(negedge clk);
    check("t3_break_nocmd", 32'(cmdN), 32'd4);
    sendFrame(8'h1B, 1'b0);
    @(negedge clk);
`ifdef PS2_WASD_EN
    check("t3_wasd_cmdn", 32'(cmdN), 32'd5);
    check("t3_wasd_val", 32'(cmdVal[4]), 32'h4);
    n0 = 5;
`else
    check("t3_plain_nocmd", 32'(cmdN), 32'd4);
    n0 = 4;
`endif

    // bad parity: error pulse, no rx_valid, flags untouched
    r0 = rxCount;
    e0 = errCount;
    sendFrame(8'h72, 1'b1);
    @(negedge clk);
    check("t4_err", 32'(errCount), 32'(e0 + 1));
    check("t4_norx", 32'(rxCount), 32'(r0));
    check("t4_nocmd", 32'(cmdN), 32'(n0));
    sendFrame(8'hE0, 1'b0); sendFrame(8'h72, 1'b0);
    @(negedge clk);
    check("t4_cmdn", 32'(cmdN), 32'(n0 + 1));
    check("t4_down", 32'(cmdVal[n0]), 32'h4);

    // partial frame then idle bus -> single timeout error
    e0 = errCount;
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10 + H) @(posedge clk);
    @(negedge clk);
    check("t5_timeout_err", 32'(errCount), 32'(e0 + 1));
    sendFrame(8'hE0, 1'b0); sendFrame(8'h6B, 1'b0);
    @(negedge clk);
    check("t5_err_once", 32'(errCount), 32'(e0 + 1));
    check("t5_cmdn", 32'(cmdN), 32'(n0 + 2));
    check("t5_left", 32'(cmdVal[n0 + 1]), 32'h5);

    // async reset mid-frame clears outputs between clock edges
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_rxbyte", 32'(rx_byte), 32'h0);
    check("t6_kbd", 32'(keyboard_signal), 32'h0);
    check("t6_rxvalid", 32'(rx_valid), 32'h0);
    check("t6_frameerr", 32'(frame_err), 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b1;
    repeat (50) @(posedge clk);
    sendFrame(8'hE0, 1'b0); sendFrame(8'h75, 1'b0);
    @(negedge clk);
    check("t6_cmdn", 32'(cmdN), 32'(n0 + 3));
    check("t6_rotate", 32'(cmdVal[n0 + 2]), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
